// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver/transmitter pair: baud divider
// computation, FIFO sizing and the receiver state encoding.
package rs232_pkg;

  localparam int FIFO_DEPTH     = 4;
  localparam int FIFO_PTR_W     = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W     = FIFO_PTR_W + 1;
  localparam int MIN_BAUD_COUNT = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Clocks per bit, rounded to nearest; very fast baud rates are clamped so
  // the half-bit start delay never collapses to zero.
  function automatic int baud_count(input real clock_freq, input real baud_rate);
    int cnt;
    cnt = $rtoi(clock_freq / baud_rate + 0.5);
    return (cnt < MIN_BAUD_COUNT) ? MIN_BAUD_COUNT : cnt;
  endfunction

endpackage

// File: rtl/axis_fifo4.sv
// Four-entry byte FIFO with simultaneous push/pop, head-of-queue read port
// and a one-cycle overrun pulse when a push finds no room.
module axis_fifo4
  import rs232_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            wdata,
  input  logic                  push,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [FIFO_CNT_W-1:0] count_nxt,
  output logic                  overrun
);

  localparam logic [FIFO_CNT_W-1:0] DEPTH_C = FIFO_CNT_W'(FIFO_DEPTH);

  logic [7:0]            mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_pop;
  logic                  do_push;

  // A pop in the same cycle frees the slot the incoming byte needs when full.
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count < DEPTH_C) || do_pop);
  assign count_nxt = count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      overrun <= push && !do_push;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rs232_to_axis.sv
// 8N1 serial receiver feeding a 4-byte AXI-stream FIFO, with RTS flow control
// and one-cycle frame-error / overrun pulses.
module rs232_to_axis
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_pin,
  output logic       rtsn_pin,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int BAUD_COUNT = baud_count(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W      = $clog2(BAUD_COUNT);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_COUNT / 2 - 1);
  localparam logic [FIFO_CNT_W-1:0] RTS_LEVEL = FIFO_CNT_W'(2);

  logic                  rxd_p0;
  logic                  rxd_p1;
  logic                  rxd;
  rx_state_t             state;
  rx_state_t             state_nxt;
  logic [CNT_W-1:0]      baud_cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [2:0]            bit_idx;
  logic [2:0]            idx_nxt;
  logic [7:0]            shreg;
  logic [7:0]            shift_nxt;
  logic                  expired;
  logic                  push;
  logic                  fe_nxt;
  logic                  pop;
  logic [FIFO_CNT_W-1:0] count;
  logic [FIFO_CNT_W-1:0] count_nxt;

  assign rxd     = rxd_p1;
  assign expired = (baud_cnt == '0);
  assign ovalid  = (count != '0);
  assign pop     = ovalid && oready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = baud_cnt - 1'b1;
    idx_nxt   = bit_idx;
    shift_nxt = shreg;
    push      = 1'b0;
    fe_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxd) begin
          state_nxt = START;
          cnt_nxt   = HALF_RELOAD;
        end
      end
      START: begin
        if (expired) begin
          if (rxd) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
            cnt_nxt   = FULL_RELOAD;
          end
        end
      end
      DATA: begin
        if (expired) begin
          shift_nxt = {rxd, shreg[7:1]};
          cnt_nxt   = FULL_RELOAD;
          idx_nxt   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (expired) begin
          cnt_nxt = FULL_RELOAD;
          if (rxd) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held break must not re-trigger until the line returns high.
        if (rxd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0/p1: input synchronizer and receiver control
  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_p0      <= 1'b1;
      rxd_p1      <= 1'b1;
      state       <= IDLE;
      frame_error <= 1'b0;
      rtsn_pin    <= 1'b1;
    end else begin
      rxd_p0      <= rxd_pin;
      rxd_p1      <= rxd_p0;
      state       <= state_nxt;
      frame_error <= fe_nxt;
      rtsn_pin    <= (count_nxt >= RTS_LEVEL);
    end
  end

  always_ff @(posedge clock) begin
    baud_cnt <= cnt_nxt;
    bit_idx  <= idx_nxt;
    shreg    <= shift_nxt;
  end

  axis_fifo4 u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wdata     (shreg),
    .push      (push),
    .pop       (pop),
    .rdata     (odata),
    .count     (count),
    .count_nxt (count_nxt),
    .overrun   (overrun)
  );

endmodule
